// File: rtl/mem_pkg.sv
// Shared types for the burst read engine.
// Holds the burst FSM state encoding and the output buffer depth.
// Imported by the top of the burst reader.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } burst_state_e;

   // Reads in flight plus buffered words may never exceed this.
   localparam int fifo_depth_lp = 2;

endpackage

// File: rtl/mem_burst_reader_if.sv
// Bundle of control, memory-side and stream-side signals of the burst reader.
// Names keep the reader's own direction suffixes; slave is the reader's view.
// master is the view of whoever drives start, supplies read data and consumes the stream.
interface mem_burst_reader_if #(
   parameter int data_width_p = 64,
   parameter int addr_width_p = 13,
   parameter int len_width_p  = addr_width_p + 1
);
   logic                      start_i;
   logic [addr_width_p-1:0]   base_addr_i;
   logic [len_width_p-1:0]    len_i;
   logic                      busy_o;
   logic                      done_o;
   logic                      mem_req_o;
   logic                      mem_wen_o;
   logic [addr_width_p-1:0]   mem_addr_o;
   logic [data_width_p/8-1:0] mem_mask_o;
   logic [data_width_p-1:0]   mem_rdata_i;
   logic                      out_valid_o;
   logic [data_width_p-1:0]   out_data_o;
   logic                      out_last_o;
   logic                      out_ready_i;

   modport slave (
      input  start_i, base_addr_i, len_i, mem_rdata_i, out_ready_i,
      output busy_o, done_o, mem_req_o, mem_wen_o, mem_addr_o, mem_mask_o,
             out_valid_o, out_data_o, out_last_o
   );

   modport master (
      output start_i, base_addr_i, len_i, mem_rdata_i, out_ready_i,
      input  busy_o, done_o, mem_req_o, mem_wen_o, mem_addr_o, mem_mask_o,
             out_valid_o, out_data_o, out_last_o
   );
endinterface

// File: rtl/stream_fifo2.sv
// Purpose: 2-entry register FIFO; entry 0 is always the head.
// Latency: a push is visible at the head the cycle after the pushing edge.
// Backpressure: none internally; the caller must never push into a full FIFO.
module stream_fifo2 #(
   parameter int data_width_p = 64
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    push_i,
   input  logic [data_width_p-1:0] push_data_i,
   input  logic                    pop_i,
   output logic [1:0]              cnt_o,
   output logic [data_width_p-1:0] head_o
);
   logic [data_width_p-1:0] e0_q;
   logic [data_width_p-1:0] e1_q;
   logic [1:0]              cnt_q;

   // Shift-register storage: pops move entry 1 down, pushes fill the first free slot.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         e0_q  <= '0;
         e1_q  <= '0;
         cnt_q <= 2'd0;
      end else begin
         case ({push_i, pop_i})
            2'b10: begin
               if (cnt_q == 2'd0) e0_q <= push_data_i;
               else               e1_q <= push_data_i;
               cnt_q <= cnt_q + 2'd1;
            end
            2'b01: begin
               e0_q  <= e1_q;
               cnt_q <= cnt_q - 2'd1;
            end
            2'b11: begin
               // Simultaneous push and pop keeps the count; only the slots shuffle.
               if (cnt_q == 2'd1) begin
                  e0_q <= push_data_i;
               end else begin
                  e0_q <= e1_q;
                  e1_q <= push_data_i;
               end
            end
            default: ;
         endcase
      end
   end

   assign cnt_o  = cnt_q;
   assign head_o = e0_q;

endmodule

// File: rtl/mem_burst_reader.sv
// Purpose: reads len consecutive words from a 1-cycle registered memory and streams them out with last.
// Latency: start edge -> request next cycle -> first word valid 3 cycles after the start edge; 1 word/cycle after.
// Backpressure: with ready low at most 2 words are buffered/in flight and issue stops until the next pop.
module mem_burst_reader
   import mem_pkg::*;
#(
   parameter int data_width_p = 64,
   parameter int depth_p      = 8192,
   parameter int addr_width_p = $clog2(depth_p),
   parameter int len_width_p  = addr_width_p + 1
) (
   input logic               clk_i,
   input logic               rst_i,
   mem_burst_reader_if.slave bus
);
   burst_state_e              state_q;
   logic [addr_width_p-1:0]   addr_q;
   logic [addr_width_p-1:0]   addr_d;
   logic [len_width_p-1:0]    issue_left_q;
   logic [len_width_p-1:0]    out_left_q;
   logic                      pending_q;
   logic [1:0]                fifo_cnt;
   logic [data_width_p-1:0]   fifo_head;
   logic                      pop;
   logic                      room;
   logic                      issue;

   // A read may be issued when buffered plus in-flight words leave room, or a pop frees a slot now.
   assign pop   = (fifo_cnt != 2'd0) && bus.out_ready_i;
   assign room  = ({1'b0, fifo_cnt} + {2'b00, pending_q}) < 3'(fifo_depth_lp);
   assign issue = (state_q == RUN) && (issue_left_q != '0) && (room || pop);

   // Address walks modulo the memory depth.
   assign addr_d = (addr_q == addr_width_p'(depth_p - 1)) ? '0 : addr_q + 1'b1;

   // Burst FSM with address, remaining-issue, remaining-output counters and the read-pending flag.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         issue_left_q <= '0;
         out_left_q   <= '0;
         pending_q    <= 1'b0;
      end else begin
         pending_q <= issue;
         case (state_q)
            IDLE: begin
               if (bus.start_i) begin
                  addr_q       <= bus.base_addr_i;
                  issue_left_q <= bus.len_i;
                  out_left_q   <= bus.len_i;
                  state_q      <= (bus.len_i != '0) ? RUN : DONE;
               end
            end
            RUN: begin
               if (issue) begin
                  addr_q       <= addr_d;
                  issue_left_q <= issue_left_q - 1'b1;
               end
               if (pop) begin
                  out_left_q <= out_left_q - 1'b1;
                  if (out_left_q == len_width_p'(1)) state_q <= DONE;
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Read data arrives the cycle after the request and is captured while pending is set.
   stream_fifo2 #(
      .data_width_p (data_width_p)
   ) u_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (pending_q),
      .push_data_i (bus.mem_rdata_i),
      .pop_i       (pop),
      .cnt_o       (fifo_cnt),
      .head_o      (fifo_head)
   );

   assign bus.busy_o      = (state_q != IDLE);
   assign bus.done_o      = (state_q == DONE);
   assign bus.mem_req_o   = issue;
   assign bus.mem_wen_o   = 1'b0;
   assign bus.mem_addr_o  = addr_q;
   assign bus.mem_mask_o  = '1;
   assign bus.out_valid_o = (fifo_cnt != 2'd0);
   assign bus.out_data_o  = fifo_head;
   assign bus.out_last_o  = (fifo_cnt != 2'd0) && (out_left_q == len_width_p'(1));

endmodule
